// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU control path: opcodes, control-word bit
// positions and micro-step numbers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned CW_PC_OUT   = 0;
  localparam int unsigned CW_PC_INC   = 1;
  localparam int unsigned CW_PC_LOAD  = 2;
  localparam int unsigned CW_MAR_IN   = 3;
  localparam int unsigned CW_RAM_OUT  = 4;
  localparam int unsigned CW_RAM_IN   = 5;
  localparam int unsigned CW_IR_IN    = 6;
  localparam int unsigned CW_IR_OUT   = 7;
  localparam int unsigned CW_A_IN     = 8;
  localparam int unsigned CW_A_OUT    = 9;
  localparam int unsigned CW_B_IN     = 10;
  localparam int unsigned CW_ALU_OUT  = 11;
  localparam int unsigned CW_ALU_SUB  = 12;
  localparam int unsigned CW_FLAGS_IN = 13;
  localparam int unsigned CW_OUT_IN   = 14;
  localparam int unsigned CW_W        = 15;

  typedef logic [CW_W-1:0] ctrl_word_t;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

endpackage

// File: rtl/control_decoder.sv
// Combinational microcode ROM: (step, opcode, flags) -> control word, plus
// markers for the instruction's final step and the halt step.
module control_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned STEP_W   = 3
) (
  input  logic [STEP_W-1:0]   step,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output ctrl_word_t          ctrl,
  output logic                last_step,
  output logic                halt_step
);

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    halt_step = 1'b0;
    case (step)
      T0: begin
        ctrl[CW_PC_OUT] = 1'b1;
        ctrl[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        ctrl[CW_RAM_OUT] = 1'b1;
        ctrl[CW_IR_IN]   = 1'b1;
        ctrl[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl[CW_IR_OUT] = 1'b1;
            ctrl[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            ctrl[CW_IR_OUT] = 1'b1;
            ctrl[CW_A_IN]   = 1'b1;
            last_step       = 1'b1;
          end
          OP_JMP: begin
            ctrl[CW_IR_OUT]  = 1'b1;
            ctrl[CW_PC_LOAD] = 1'b1;
            last_step        = 1'b1;
          end
          OP_JC, OP_JZ: begin
            // A jump not taken drives nothing at all, not even the operand.
            if ((opcode == OP_JC) ? carry_flag : zero_flag) begin
              ctrl[CW_IR_OUT]  = 1'b1;
              ctrl[CW_PC_LOAD] = 1'b1;
            end
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctrl[CW_A_OUT]  = 1'b1;
            ctrl[CW_OUT_IN] = 1'b1;
            last_step       = 1'b1;
          end
          OP_HLT:  halt_step = 1'b1;
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl[CW_RAM_OUT] = 1'b1;
            ctrl[CW_A_IN]    = 1'b1;
            last_step        = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[CW_RAM_OUT] = 1'b1;
            ctrl[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            ctrl[CW_A_OUT]  = 1'b1;
            ctrl[CW_RAM_IN] = 1'b1;
            last_step       = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl[CW_ALU_OUT]  = 1'b1;
          ctrl[CW_A_IN]     = 1'b1;
          ctrl[CW_FLAGS_IN] = 1'b1;
          ctrl[CW_ALU_SUB]  = (opcode == OP_SUB);
        end
        last_step = 1'b1;
      end
      // Unused step encodings fall back to fetch.
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: step counter and halt latch around the microcode
// decoder, with synchronous clear that also blanks every control line.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned STEP_W   = 3
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [7:0]        instr,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic              pc_out,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              mar_in,
  output logic              ram_out,
  output logic              ram_in,
  output logic              ir_in,
  output logic              ir_out,
  output logic              a_in,
  output logic              a_out,
  output logic              b_in,
  output logic              alu_out,
  output logic              alu_sub,
  output logic              flags_in,
  output logic              out_in,
  output logic              halted,
  output logic [STEP_W-1:0] step
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  ctrl_word_t        ctrl_raw, ctrl;
  logic              last_step, halt_step;

  control_decoder #(
    .OPCODE_W(OPCODE_W),
    .STEP_W  (STEP_W)
  ) u_decoder (
    .step      (step_q),
    .opcode    (instr[7:8-OPCODE_W]),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag),
    .ctrl      (ctrl_raw),
    .last_step (last_step),
    .halt_step (halt_step)
  );

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (clear) begin
      step_d   = '0;
      halted_d = 1'b0;
    end else if (!halted_q) begin
      // Entering halt freezes step where it is.
      if (halt_step) begin
        halted_d = 1'b1;
      end else if (last_step) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    step_q   <= step_d;
    halted_q <= halted_d;
  end

  always_comb begin
    ctrl = ctrl_raw;
    if (clear || halted_q) begin
      ctrl = '0;
    end
  end

  assign pc_out   = ctrl[CW_PC_OUT];
  assign pc_inc   = ctrl[CW_PC_INC];
  assign pc_load  = ctrl[CW_PC_LOAD];
  assign mar_in   = ctrl[CW_MAR_IN];
  assign ram_out  = ctrl[CW_RAM_OUT];
  assign ram_in   = ctrl[CW_RAM_IN];
  assign ir_in    = ctrl[CW_IR_IN];
  assign ir_out   = ctrl[CW_IR_OUT];
  assign a_in     = ctrl[CW_A_IN];
  assign a_out    = ctrl[CW_A_OUT];
  assign b_in     = ctrl[CW_B_IN];
  assign alu_out  = ctrl[CW_ALU_OUT];
  assign alu_sub  = ctrl[CW_ALU_SUB];
  assign flags_in = ctrl[CW_FLAGS_IN];
  assign out_in   = ctrl[CW_OUT_IN];
  assign halted   = halted_q;
  assign step     = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// instruction streams against an instruction-level reference model.
module tb_control_sequencer;

  logic       clock;
  logic       clear;
  logic [7:0] instr;
  logic       carry_flag, zero_flag;
  logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted;
  logic [2:0] step;

  control_sequencer #(
    .OPCODE_W(4),
    .STEP_W  (3)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .instr     (instr),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag),
    .pc_out    (pc_out),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mar_in    (mar_in),
    .ram_out   (ram_out),
    .ram_in    (ram_in),
    .ir_in     (ir_in),
    .ir_out    (ir_out),
    .a_in      (a_in),
    .a_out     (a_out),
    .b_in      (b_in),
    .alu_out   (alu_out),
    .alu_sub   (alu_sub),
    .flags_in  (flags_in),
    .out_in    (out_in),
    .halted    (halted),
    .step      (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-local bit order for the observed control vector.
  localparam logic [14:0] M_PC_OUT   = 15'h4000;
  localparam logic [14:0] M_PC_INC   = 15'h2000;
  localparam logic [14:0] M_PC_LOAD  = 15'h1000;
  localparam logic [14:0] M_MAR_IN   = 15'h0800;
  localparam logic [14:0] M_RAM_OUT  = 15'h0400;
  localparam logic [14:0] M_RAM_IN   = 15'h0200;
  localparam logic [14:0] M_IR_IN    = 15'h0100;
  localparam logic [14:0] M_IR_OUT   = 15'h0080;
  localparam logic [14:0] M_A_IN     = 15'h0040;
  localparam logic [14:0] M_A_OUT    = 15'h0020;
  localparam logic [14:0] M_B_IN     = 15'h0010;
  localparam logic [14:0] M_ALU_OUT  = 15'h0008;
  localparam logic [14:0] M_ALU_SUB  = 15'h0004;
  localparam logic [14:0] M_FLAGS_IN = 15'h0002;
  localparam logic [14:0] M_OUT_IN   = 15'h0001;
  localparam logic [14:0] M_BUS = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;

  logic [14:0] obs;
  assign obs = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: cycle position within the instruction and halt.
  int m_step;
  bit m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, want);
    end
  endtask

  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] exp_ctrl(input int st, input logic [3:0] op,
                                           input logic c, input logic z);
    logic [14:0] r;
    r = '0;
    if (st == 0) r = M_PC_OUT | M_MAR_IN;
    else if (st == 1) r = M_RAM_OUT | M_IR_IN | M_PC_INC;
    else if (st == 2) begin
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: r = M_IR_OUT | M_MAR_IN;
        4'h5: r = M_IR_OUT | M_A_IN;
        4'h6: r = M_IR_OUT | M_PC_LOAD;
        4'h7: r = c ? (M_IR_OUT | M_PC_LOAD) : '0;
        4'h8: r = z ? (M_IR_OUT | M_PC_LOAD) : '0;
        4'hE: r = M_A_OUT | M_OUT_IN;
        default: r = '0;
      endcase
    end else if (st == 3) begin
      case (op)
        4'h1:       r = M_RAM_OUT | M_A_IN;
        4'h2, 4'h3: r = M_RAM_OUT | M_B_IN;
        4'h4:       r = M_A_OUT | M_RAM_IN;
        default:    r = '0;
      endcase
    end else if (st == 4 && (op == 4'h2 || op == 4'h3)) begin
      r = M_ALU_OUT | M_A_IN | M_FLAGS_IN | ((op == 4'h3) ? M_ALU_SUB : 15'h0);
    end
    return r;
  endfunction

  // One clock: drive at posedge+1, check mid-cycle, advance model after the edge.
  task automatic do_cycle(input logic clr, input logic [7:0] ib, input logic c, input logic z);
    logic [14:0] e;
    clear = clr;
    instr = ib;
    carry_flag = c;
    zero_flag = z;
    #3;
    e = (clr || m_halted) ? 15'h0 : exp_ctrl(m_step, ib[7:4], c, z);
    check_eq("ctrl", 32'(obs), 32'(e));
    check_eq("step", 32'(step), 32'(m_step));
    check_eq("halted", 32'(halted), 32'(m_halted));
    check_eq("bus_excl", 32'($countones(obs & M_BUS) <= 1), 32'd1);
    @(posedge clock);
    #1;
    if (clr) begin
      m_step = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_step == 2 && ib[7:4] == 4'hF) m_halted = 1'b1;
      else if (m_step + 1 == ilen(ib[7:4])) m_step = 0;
      else m_step++;
    end
  endtask

  // Runs one instruction from T0; fetch cycles see junk on instr.
  task automatic run_instr(input logic [7:0] ib, input logic c, input logic z,
                           input int exp_len);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, (m_step < 2) ? 8'($urandom) : ib, c, z);
      n++;
      if (step == 3'd0) break;
    end
    check_eq("instr_len", 32'(n), 32'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cur;
    m_step = 0;
    m_halted = 1'b0;
    clear = 1'b1;
    instr = 8'h00;
    carry_flag = 1'b0;
    zero_flag = 1'b0;
    @(posedge clock);
    #1;
    // Reset: outputs blanked while clear is held, before state is known.
    for (int i = 0; i < 2; i++) begin
      #3;
      check_eq("clear_ctrl", 32'(obs), 32'd0);
      @(posedge clock);
      #1;
    end
    m_step = 0;
    m_halted = 1'b0;
    clear = 1'b0;
    #3;
    check_eq("rst_step", 32'(step), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("t0_fetch", 32'(obs), 32'(M_PC_OUT | M_MAR_IN));

    run_instr(8'h1A, 1'b0, 1'b0, 4);
    run_instr(8'h3C, 1'b0, 1'b0, 5);
    run_instr(8'h2C, 1'b1, 1'b1, 5);
    run_instr(8'h4C, 1'b0, 1'b0, 4);
    run_instr(8'h75, 1'b1, 1'b0, 3);
    run_instr(8'h75, 1'b0, 1'b1, 3);
    run_instr(8'h83, 1'b0, 1'b1, 3);
    run_instr(8'h83, 1'b1, 1'b0, 3);
    run_instr(8'hB3, 1'b1, 1'b1, 3);
    run_instr(8'hE0, 1'b0, 1'b0, 3);
    run_instr(8'h57, 1'b0, 1'b0, 3);

    // HLT: freezes for 20 cycles, then one clear cycle restarts fetch.
    for (int i = 0; i < 3; i++) do_cycle(1'b0, (m_step < 2) ? 8'h9F : 8'hF0, 1'b0, 1'b0);
    check_eq("hlt_entered", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    check_eq("hlt_step_frozen", 32'(step), 32'd2);
    do_cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    check_eq("hlt_exit_halted", 32'(halted), 32'd0);
    check_eq("hlt_exit_step", 32'(step), 32'd0);
    run_instr(8'h6F, 1'b0, 1'b0, 3);

    // Clear during T3 of ADD abandons it; T4 never appears.
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    do_cycle(1'b0, 8'h11, 1'b0, 1'b0);
    do_cycle(1'b0, 8'h27, 1'b0, 1'b0);
    do_cycle(1'b1, 8'h27, 1'b0, 1'b0);
    check_eq("clear_mid_step", 32'(step), 32'd0);
    run_instr(8'h1C, 1'b0, 1'b0, 4);

    // Random streams, with occasional clears and forced exit from halt.
    cur = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      logic clr;
      if (m_step == 0 && !m_halted) cur = 8'($urandom);
      clr = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 5) == 0);
      do_cycle(clr, (m_step < 2) ? 8'($urandom) : cur, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit CPU. It sits directly upstream of the datapath registers: it consumes the instruction register output and drives the clock_enable / output-enable lines of the PC, MAR, RAM, IR, A, B, ALU, flags and output registers.
- A step counter walks each instruction through fetch (T0–T1) and execute (T2–T4). Execution terminates early once the instruction's last micro-step completes.

Parameters:
- OPCODE_W, 4, opcode width; the opcode is instr[7:4], and the operand/address is instr[3:0].
- STEP_W, 3, step counter width; steps 0..4 are used.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- instr  in  8  instruction register q.
- carry_flag  in  1  registered carry flag.
- zero_flag  in  1  registered zero flag.
- pc_out  out  1  PC drives bus.
- pc_inc  out  1  PC increment enable.
- pc_load  out  1  PC load from bus.
- mar_in  out  1  MAR clock_enable.
- ram_out  out  1  RAM drives bus.
- ram_in  out  1  RAM write.
- ir_in  out  1  IR clock_enable.
- ir_out  out  1  IR low nibble drives bus.
- a_in  out  1  A clock_enable.
- a_out  out  1  A drives bus.
- b_in  out  1  B clock_enable.
- alu_out  out  1  ALU drives bus.
- alu_sub  out  1  ALU subtract select.
- flags_in  out  1  flags register clock_enable.
- out_in  out  1  output register clock_enable.
- halted  out  1  CPU stopped.
- step  out  3  current micro-step, for debug.

Behaviour:
- State: step[2:0] and halted, both registers.
- Control outputs are a combinational decode of (step, opcode, carry_flag, zero_flag, halted). Registers sample them on the same rising edge that advances step.
- clear (synchronous, takes priority over everything):
  - Next edge: step=0, halted=0.
  - While clear is held, all control outputs are forced to 0.
  - A clear mid-instruction abandons the instruction; the next cycle is T0.
- Fetch, for every opcode:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
  - instr is ignored in T0/T1; decode uses the instr value latched at the end of T1.
- Execute. "end" means step returns to 0 on the next edge; otherwise step increments.
  - LDA 0x1: T2 ir_out, mar_in; T3 ram_out, a_in, end.
  - ADD 0x2: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, flags_in, end.
  - SUB 0x3: as ADD, with alu_sub=1 in T4 only.
  - STA 0x4: T2 ir_out, mar_in; T3 a_out, ram_in, end.
  - LDI 0x5: T2 ir_out, a_in, end.
  - JMP 0x6: T2 ir_out, pc_load, end.
  - JC 0x7: T2 ir_out, pc_load if carry_flag=1 (otherwise no enables), end.
  - JZ 0x8: as JC, using zero_flag.
  - OUT 0xE: T2 a_out, out_in, end.
  - HLT 0xF: T2 no enables; halted=1 at the next edge.
  - NOP 0x0 and undefined opcodes 0x9–0xD: T2 no enables, end.
- Instruction lengths: 3 cycles (LDI, JMP, JC, JZ, OUT, NOP), 4 cycles (LDA, STA), 5 cycles (ADD, SUB).
- Halted: all control outputs are 0 and step is frozen at its value when halt was entered; only clear exits.
- At most one bus driver is asserted in any step (pc_out, ram_out, ir_out, a_out, alu_out are mutually exclusive). The bench asserts this.
- Flags are sampled combinationally in T2; their value in other steps is irrelevant.
- Reset values: step=0, halted=0, all control outputs 0.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_NOP..OP_HLT);
  - control-word bit indices;
  - step constants T0..T4.
- One sub-module, control_decoder: purely combinational (step, opcode, carry_flag, zero_flag) -> control word.
- control_sequencer holds the step/halted registers, the end/halt logic and the clear gating.

Test Plan:
- Reset: clear=1 for 2 cycles.
  - During clear: all control outputs are 0.
  - After clear drops: step=0, halted=0; in T0, pc_out=1 and mar_in=1.
- LDA: instr=0x1A after T1.
  - T2: ir_out=1, mar_in=1.
  - T3: ram_out=1, a_in=1.
  - Next cycle step=0; total 4 cycles.
- SUB: instr=0x3C.
  - T4: alu_out=1, a_in=1, flags_in=1, alu_sub=1.
  - alu_sub=0 in T0–T3.
  - Back to T0 after 5 cycles.
- Conditional jumps:
  - JC instr=0x75 with carry_flag=1: T2 pc_load=1, ir_out=1.
  - Same with carry_flag=0: T2 all enables 0.
  - Both variants last 3 cycles.
  - Repeat for JZ (0x8x) with zero_flag.
- HLT: instr=0xF0.
  - halted=1 after T2 and stays 1 for 20 cycles, with step constant and all enables 0.
  - clear=1 for one cycle: halted=0, step=0, and fetch resumes.
- Clear mid-instruction and undefined opcode:
  - Assert clear at T3 of ADD: the next cycle is T0 and T4 never occurs.
  - Undefined opcode instr=0xB3: T2 has no enables and is followed by T0.
